stg_if: RTL

- Instruction-fetch stage of the diad pipeline, between the instruction-address (IA) stage and the decode (ID) stage.
- Takes the PC that IA presents on the IAIF boundary and issues a synchronous read to instruction memory.
- Presents pc/instr/valid on the IFID boundary.
- Handles downstream stall by holding the returned instruction word, and handles pipeline flush by inserting a bubble.

---
 rtl/stg_if.sv | 115 +++++++++++
 1 files changed

// File: rtl/stg_if.sv
// Instruction-fetch stage of the diad pipeline.
// Sits between the instruction-address stage (IAIF boundary) and decode
// (IFID boundary). The PC from IA goes straight to a synchronous instruction
// memory, and the word that comes back one cycle later is steered onto the
// IFID boundary together with the registered PC. Downstream stalls freeze
// the boundary, and flushes turn the in-flight fetch into a bubble.
module stg_if #(
    parameter int unsigned         PC_W      = 24,
    parameter int unsigned         INSTR_W   = 24,
    parameter logic [INSTR_W-1:0]  NOP_INSTR = '0,
    parameter int unsigned         CNT_W     = 32
) (
    input  logic               iw_clk,
    input  logic               iw_rst,
    // IAIF boundary
    input  logic [PC_W-1:0]    iw_pc,
    input  logic               iw_valid,
    // pipeline control
    input  logic               iw_stall,
    input  logic               iw_flush,
    // instruction memory
    output logic [PC_W-1:0]    ow_imem_addr,
    output logic               ow_imem_en,
    input  logic [INSTR_W-1:0] iw_imem_data,
    // IFID boundary
    output logic [PC_W-1:0]    ow_pc,
    output logic [INSTR_W-1:0] ow_instr,
    output logic               ow_valid,
    // backpressure and statistics
    output logic               ow_ia_stall,
    output logic [CNT_W-1:0]   ow_fetch_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // IFID boundary state
    logic [PC_W-1:0]    r_pc;
    logic               r_valid;
    // Copy of the memory word taken on the first stalled edge; the memory
    // output is not guaranteed to stay put once its enable has dropped.
    logic               r_held;
    logic [INSTR_W-1:0] r_hold;
    // Instructions consumed by ID since reset
    logic [CNT_W-1:0]   r_cnt;

    // The counter advances when the stage advances while holding a real
    // instruction, i.e. when ID takes the current IFID contents.
    logic               consume;

    // Request a read whenever IA has a real PC and nothing downstream stalls;
    // reset gates the enable so no read is issued while reset is asserted.
    always_comb begin
        ow_imem_addr = iw_pc;
        ow_imem_en   = iw_valid & ~iw_stall & ~iw_rst;
        ow_ia_stall  = iw_stall;
    end

    assign consume = ~iw_flush & ~iw_stall & r_valid;

    // PC/valid pipeline register: flush loads a bubble, stall freezes, otherwise advance.
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            r_pc    <= '0;
            r_valid <= 1'b0;
        end else if (iw_flush) begin
            r_pc    <= iw_pc;
            r_valid <= 1'b0;
        end else if (!iw_stall) begin
            r_pc    <= iw_pc;
            r_valid <= iw_valid;
        end
    end

    // Hold register: capture the memory word on the first stalled edge, keep it
    // for the rest of the stall, and drop it on flush or on the next advance.
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            r_held <= 1'b0;
            r_hold <= NOP_INSTR;
        end else if (iw_flush) begin
            r_held <= 1'b0;
        end else if (iw_stall) begin
            if (!r_held) begin
                r_hold <= iw_imem_data;
                r_held <= 1'b1;
            end
        end else begin
            r_held <= 1'b0;
        end
    end

    // Delivered-instruction counter, wrapping naturally at 2^CNT_W.
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            r_cnt <= '0;
        end else if (consume) begin
            r_cnt <= r_cnt + CNT_ONE;
        end
    end

    // IFID instruction select: bubble, then held copy, then live memory data.
    always_comb begin
        ow_instr = iw_imem_data;
        if (!r_valid) begin
            ow_instr = NOP_INSTR;
        end else if (r_held) begin
            ow_instr = r_hold;
        end
    end

    assign ow_pc        = r_pc;
    assign ow_valid     = r_valid;
    assign ow_fetch_cnt = r_cnt;

endmodule
